ifetch_unit: RTL and testbench

- Instruction fetch unit. Owns the PC and fetches 32-bit instructions from instruction memory over a request/grant/response handshake.
- Presents each instruction to the decode controller with a valid/ready handshake.
- Consumes the controller's npc_op/br_op result, the branch flag, the immediate and the ALU target through a resolve port, and computes the next PC.
- Non-speculative by default: one instruction in flight.

---
 rtl/ifetch_unit_if.sv | 41 ++++
 rtl/ifetch_unit.sv | 175 +++++++++++++++++
 tb/tb_ifetch_unit.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// Bundle of the ifetch_unit bus signals: instruction-memory request/response,
// the instruction handshake towards decode, and the next-PC resolve port.
// The master modport is the fetch unit; the slave modport is its environment.
interface ifetch_unit_if;
    // Instruction memory
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    // Decode handshake
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    // Next-PC resolve
    logic        resolve_valid;
    logic [1:0]  npc_op;
    logic        br;
    logic [31:0] imm;
    logic [31:0] abs_target;
    logic        misalign;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output inst_valid, inst, inst_pc,
        input  inst_ready,
        input  resolve_valid, npc_op, br, imm, abs_target,
        output misalign
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  inst_valid, inst, inst_pc,
        output inst_ready,
        output resolve_valid, npc_op, br, imm, abs_target,
        input  misalign
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one 32-bit word per instruction
// over a req/gnt/rvalid handshake, hands it to decode with valid/ready and
// waits for the next-PC resolve before fetching again.
// Optional macro IFU_PREFETCH_EN adds a one-entry pc+4 prefetch buffer that is
// filled while the current instruction sits in decode; a wrong-path speculative
// response is counted and dropped on arrival.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_unit_if.master bus
);

    localparam logic [1:0] NPC_JMP    = 2'b01;
    localparam logic [1:0] NPC_ABSJMP = 2'b10;

    typedef enum logic [1:0] {StReq, StWait, StHold, StRes} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        misalign_q, misalign_d;
    logic [31:0] target;
    logic [31:0] npc;
    logic        rsp_ok;

`ifdef IFU_PREFETCH_EN
    logic        pf_valid_q, pf_valid_d;
    logic        pf_pending_q, pf_pending_d;
    logic [31:0] pf_data_q, pf_data_d;
    logic [1:0]  drop_cnt_q, drop_cnt_d;
    logic [31:0] pf_pc;
    logic        spec_req;
    logic        rsp_drop;
    logic        pf_rsp;
    logic        pf_out_now;
    logic        pf_have;
    logic        drop_inc;

    // Only pc+4 is ever prefetched, so the buffer tag is implied by the PC.
    assign pf_pc      = pc_q + 32'd4;
    assign spec_req   = ((state_q == StHold) || (state_q == StRes)) && !pf_pending_q && !pf_valid_q;
    // Responses are in order: wrong-path data always precedes any newer request.
    assign rsp_drop   = bus.imem_rvalid && (drop_cnt_q != 2'd0);
    assign pf_rsp     = bus.imem_rvalid && (drop_cnt_q == 2'd0) && pf_pending_q;
    assign pf_out_now = (pf_pending_q && !pf_rsp) || (spec_req && bus.imem_gnt);
    assign pf_have    = pf_valid_q || pf_rsp;
    assign rsp_ok     = bus.imem_rvalid && (drop_cnt_q == 2'd0);
    assign drop_cnt_d = drop_cnt_q + {1'b0, drop_inc} - {1'b0, rsp_drop};

    assign bus.imem_req  = !rst && ((state_q == StReq) || spec_req);
    assign bus.imem_addr = (state_q == StReq) ? pc_q : pf_pc;
`else
    assign rsp_ok        = bus.imem_rvalid;
    assign bus.imem_req  = !rst && (state_q == StReq);
    assign bus.imem_addr = pc_q;
`endif

    assign bus.inst_valid = !rst && (state_q == StHold);
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.misalign   = !rst && misalign_q;

    // Next-PC target from the resolve fields; low two bits are forced to a word address.
    always_comb begin
        target = pc_q + 32'd4;
        case (bus.npc_op)
            NPC_JMP:    target = bus.br ? (pc_q + bus.imm) : (pc_q + 32'd4);
            NPC_ABSJMP: target = bus.abs_target & ~32'h1;
            default:    target = pc_q + 32'd4;
        endcase
        npc = {target[31:2], 2'b00};
    end

    // Fetch FSM next state, PC update and instruction capture.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        misalign_d = 1'b0;
`ifdef IFU_PREFETCH_EN
        pf_valid_d   = pf_valid_q;
        pf_pending_d = pf_pending_q;
        pf_data_d    = pf_data_q;
        drop_inc     = 1'b0;
        if (spec_req && bus.imem_gnt) begin
            pf_pending_d = 1'b1;
        end
        if (pf_rsp) begin
            pf_pending_d = 1'b0;
            pf_valid_d   = 1'b1;
            pf_data_d    = bus.imem_rdata;
        end
`endif
        unique case (state_q)
            StReq: begin
                if (bus.imem_gnt) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (rsp_ok) begin
                    inst_d    = bus.imem_rdata;
                    inst_pc_d = pc_q;
                    state_d   = StHold;
                end
            end
            StHold: begin
                if (bus.inst_ready) begin
                    state_d = StRes;
                end
            end
            StRes: begin
                if (bus.resolve_valid) begin
                    misalign_d = target[1];
                    pc_d       = npc;
                    state_d    = StReq;
`ifdef IFU_PREFETCH_EN
                    pf_valid_d   = 1'b0;
                    pf_pending_d = 1'b0;
                    if ((npc == pf_pc) && pf_have) begin
                        state_d   = StHold;
                        inst_d    = pf_valid_q ? pf_data_q : bus.imem_rdata;
                        inst_pc_d = npc;
                    end else if ((npc == pf_pc) && pf_out_now) begin
                        // The in-flight speculative fetch becomes the demand fetch.
                        state_d = StWait;
                    end else begin
                        drop_inc = pf_out_now;
                    end
`endif
                end
            end
            default: state_d = StReq;
        endcase
    end

    // Core state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StReq;
            pc_q       <= RESET_PC;
            inst_q     <= 32'h0;
            inst_pc_q  <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef IFU_PREFETCH_EN
    // Prefetch buffer and wrong-path drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pf_valid_q   <= 1'b0;
            pf_pending_q <= 1'b0;
            pf_data_q    <= 32'h0;
            drop_cnt_q   <= 2'd0;
        end else begin
            pf_valid_q   <= pf_valid_d;
            pf_pending_q <= pf_pending_d;
            pf_data_q    <= pf_data_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: behavioural instruction memory with programmable
// latency and grant stalls, a scoreboard of expected presented PCs, a table of
// next-PC vectors and hand-written reset/backpressure/prefetch sequences.
module tb_ifetch_unit;

    localparam logic [31:0] RstPc  = 32'h0000_1000;
    localparam logic [1:0]  OpPc4  = 2'b00;
    localparam logic [1:0]  OpJmp  = 2'b01;
    localparam logic [1:0]  OpAbs  = 2'b10;
    localparam logic [1:0]  OpRsvd = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ifetch_unit_if bus ();

    ifetch_unit #(
        .RESET_PC (RstPc)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mem_lat = 1;
    int gnt_block = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mem_q[$];

    logic [31:0] exp_pc_q[$];

    typedef struct {
        logic [31:0] start;
        logic [1:0]  op;
        logic        br;
        logic [31:0] imm;
        logic [31:0] abs_t;
        logic [31:0] exp_next;
        logic        exp_mis;
    } vec_t;
    vec_t vecs[10];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: acts just after each falling edge, responses in order.
    initial begin
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (rst) begin
                mem_q.delete();
                bus.imem_rvalid = 1'b0;
                bus.imem_gnt    = 1'b1;
            end else begin
                if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_word(mem_q[0].addr);
                    void'(mem_q.pop_front());
                end else begin
                    bus.imem_rvalid = 1'b0;
                    bus.imem_rdata  = 32'h0;
                end
                if (gnt_block > 0) begin
                    bus.imem_gnt = 1'b0;
                    gnt_block--;
                end else begin
                    bus.imem_gnt = 1'b1;
                end
                if (bus.imem_req && bus.imem_gnt) begin
                    mem_q.push_back('{addr: bus.imem_addr, due: cyc + mem_lat});
                end
            end
        end
    end

    task automatic wait_inst(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.inst_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL inst_timeout: inst_valid=0 after 60 cycles, required 1");
        end
    endtask

    // Compare the presented instruction with the scoreboard, then accept it.
    task automatic accept();
        logic [31:0] e;
        if (exp_pc_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_inst: got pc %h, scoreboard empty", bus.inst_pc);
        end else begin
            e = exp_pc_q.pop_front();
            check32("inst_pc", bus.inst_pc, e);
            check32("inst_data", bus.inst, mem_word(e));
        end
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
    endtask

    task automatic resolve(input logic [1:0] op, input logic br, input logic [31:0] imm,
                           input logic [31:0] abs_t, input logic [31:0] exp_next,
                           input logic exp_mis, input int blk);
        bus.resolve_valid = 1'b1;
        bus.npc_op        = op;
        bus.br            = br;
        bus.imm           = imm;
        bus.abs_target    = abs_t;
        exp_pc_q.push_back(exp_next);
        @(negedge clk);
        bus.resolve_valid = 1'b0;
        gnt_block         = blk;
        check32("misalign_pulse", {31'h0, bus.misalign}, {31'h0, exp_mis});
`ifndef IFU_PREFETCH_EN
        check32("req_after_resolve", {31'h0, bus.imem_req}, 32'h1);
        check32("addr_after_resolve", bus.imem_addr, exp_next);
        for (int i = 0; i < blk; i++) begin
            @(negedge clk);
            check32("req_held_no_gnt", {31'h0, bus.imem_req}, 32'h1);
            check32("addr_stable_no_gnt", bus.imem_addr, exp_next);
        end
`endif
        @(negedge clk);
        check32("misalign_clear", {31'h0, bus.misalign}, 32'h0);
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        wait_inst(ok);
        if (!ok) return;
        accept();
        resolve(OpAbs, 1'b0, 32'h0, v.start, v.start, 1'b0, 0);
        wait_inst(ok);
        if (!ok) return;
        accept();
        resolve(v.op, v.br, v.imm, v.abs_t, v.exp_next, v.exp_mis, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        logic [31:0] held_inst;
        logic [31:0] held_pc;

        bus.inst_ready    = 1'b0;
        bus.resolve_valid = 1'b0;
        bus.npc_op        = 2'b00;
        bus.br            = 1'b0;
        bus.imm           = 32'h0;
        bus.abs_target    = 32'h0;

        vecs[0] = '{32'h0000_1000, OpPc4,  1'b0, 32'h0,         32'h0,         32'h0000_1004, 1'b0};
        vecs[1] = '{32'h0000_2000, OpJmp,  1'b1, 32'hFFFF_FFF8, 32'h0,         32'h0000_1FF8, 1'b0};
        vecs[2] = '{32'h0000_2000, OpJmp,  1'b0, 32'hFFFF_FFF8, 32'h0,         32'h0000_2004, 1'b0};
        vecs[3] = '{32'h0000_2000, OpAbs,  1'b0, 32'h0,         32'h0000_3011, 32'h0000_3010, 1'b0};
        vecs[4] = '{32'h0000_2000, OpAbs,  1'b0, 32'h0,         32'h0000_3012, 32'h0000_3010, 1'b1};
        vecs[5] = '{32'hFFFF_FFFC, OpPc4,  1'b0, 32'h0,         32'h0,         32'h0000_0000, 1'b0};
        vecs[6] = '{32'h0000_4000, OpRsvd, 1'b1, 32'h0000_0100, 32'h0000_8000, 32'h0000_4004, 1'b0};
        vecs[7] = '{32'h0000_5000, OpJmp,  1'b1, 32'h0000_0006, 32'h0,         32'h0000_5004, 1'b1};
        vecs[8] = '{32'h9000_0000, OpJmp,  1'b1, 32'h7FFF_FFF0, 32'h0,         32'h0FFF_FFF0, 1'b0};
        vecs[9] = '{32'h0000_2000, OpAbs,  1'b0, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b1};

        // Reset state
        @(negedge clk);
        check32("rst_imem_req", {31'h0, bus.imem_req}, 32'h0);
        check32("rst_inst_valid", {31'h0, bus.inst_valid}, 32'h0);
        check32("rst_misalign", {31'h0, bus.misalign}, 32'h0);
        check32("rst_inst", bus.inst, 32'h0);
        check32("rst_inst_pc", bus.inst_pc, 32'h0);
        rst = 1'b0;
        exp_pc_q.push_back(RstPc);
        #1;
        check32("first_req", {31'h0, bus.imem_req}, 32'h1);
        check32("first_addr", bus.imem_addr, RstPc);

        // First instruction, sequential resolve
        wait_inst(ok);
        if (ok) begin
            accept();
            resolve(OpPc4, 1'b0, 32'h0, 32'h0, RstPc + 32'd4, 1'b0, 0);
        end

        // Next-PC vectors
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Decode backpressure
        wait_inst(ok);
        if (ok) begin
            held_inst = bus.inst;
            held_pc   = bus.inst_pc;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check32("bp_valid", {31'h0, bus.inst_valid}, 32'h1);
                check32("bp_inst", bus.inst, held_inst);
                check32("bp_pc", bus.inst_pc, held_pc);
`ifndef IFU_PREFETCH_EN
                check32("bp_no_req", {31'h0, bus.imem_req}, 32'h0);
`endif
            end
            accept();
            // Grant withheld for three cycles
            resolve(OpAbs, 1'b0, 32'h0, 32'h0000_7000, 32'h0000_7000, 1'b0, 3);
        end

        // Reset while waiting for a response
        wait_inst(ok);
        if (ok) begin
            accept();
            mem_lat = 4;
            resolve(OpAbs, 1'b0, 32'h0, 32'h0000_6000, 32'h0000_6000, 1'b0, 0);
            rst = 1'b1;
            exp_pc_q.delete();
            @(negedge clk);
            rst = 1'b0;
            mem_lat = 1;
            exp_pc_q.push_back(RstPc);
            #1;
            check32("midrst_req", {31'h0, bus.imem_req}, 32'h1);
            check32("midrst_addr", bus.imem_addr, RstPc);
            check32("midrst_valid", {31'h0, bus.inst_valid}, 32'h0);
            wait_inst(ok);
            if (ok) begin
                accept();
                resolve(OpPc4, 1'b0, 32'h0, 32'h0, RstPc + 32'd4, 1'b0, 0);
            end
        end

`ifdef IFU_PREFETCH_EN
        // Sequential hit from the prefetch buffer
        wait_inst(ok);
        if (ok) begin
            accept();
            repeat (3) @(negedge clk);
            mem_lat = 8;
            bus.resolve_valid = 1'b1;
            bus.npc_op        = OpPc4;
            exp_pc_q.push_back(RstPc + 32'd8);
            @(negedge clk);
            bus.resolve_valid = 1'b0;
            check32("pf_hit_valid", {31'h0, bus.inst_valid}, 32'h1);
            accept();
            // Wrong-path speculative response still in flight
            resolve(OpAbs, 1'b0, 32'h0, 32'h0000_8000, 32'h0000_8000, 1'b0, 0);
            wait_inst(ok);
            if (ok) begin
                accept();
                mem_lat = 1;
                resolve(OpAbs, 1'b0, 32'h0, 32'h0000_9000, 32'h0000_9000, 1'b0, 0);
                wait_inst(ok);
                if (ok) accept();
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
